// File: rtl/axil_request_master.sv
// Single-outstanding AXI4-Lite master: turns a valid/ready request into one AW+W+B or AR+R
// transaction and returns data/error on a valid/ready response port, with a B/R watchdog.
module axil_request_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  localparam logic [2:0] IDLE         = 3'd0;
  localparam logic [2:0] WR_ADDR_DATA = 3'd1;
  localparam logic [2:0] WAIT_B       = 3'd2;
  localparam logic [2:0] RD_ADDR      = 3'd3;
  localparam logic [2:0] WAIT_R       = 3'd4;
  localparam logic [2:0] RESP         = 3'd5;

  localparam int              WDOG_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit              WDOG_EN   = (TIMEOUT_CYCLES != 0);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] reqAddr_q, reqAddr_d;
  logic [DATA_WIDTH-1:0] reqData_q, reqData_d;
  logic [STRB_WIDTH-1:0] reqStrb_q, reqStrb_d;
  logic                  awValid_q, awValid_d;
  logic                  wValid_q, wValid_d;
  logic                  arValid_q, arValid_d;
  logic [DATA_WIDTH-1:0] respData_q, respData_d;
  logic                  respError_q, respError_d;
  logic [WDOG_W-1:0]     wdogCnt_q, wdogCnt_d;

  logic awDone, wDone, wdogExpired;

  // A channel counts as done once its valid has been accepted, either earlier or this cycle.
  assign awDone      = !awValid_q || m_axil_awready;
  assign wDone       = !wValid_q || m_axil_wready;
  assign wdogExpired = WDOG_EN && (wdogCnt_q == WDOG_LAST);

  always_comb begin
    state_d     = state_q;
    reqAddr_d   = reqAddr_q;
    reqData_d   = reqData_q;
    reqStrb_d   = reqStrb_q;
    awValid_d   = awValid_q;
    wValid_d    = wValid_q;
    arValid_d   = arValid_q;
    respData_d  = respData_q;
    respError_d = respError_q;
    wdogCnt_d   = wdogCnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          reqAddr_d = req_addr;
          reqData_d = req_wdata;
          reqStrb_d = req_wstrb;
          if (req_write) begin
            awValid_d = 1'b1;
            wValid_d  = 1'b1;
            state_d   = WR_ADDR_DATA;
          end else begin
            arValid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end
      WR_ADDR_DATA: begin
        if (awValid_q && m_axil_awready) awValid_d = 1'b0;
        if (wValid_q && m_axil_wready) wValid_d = 1'b0;
        if (awDone && wDone) begin
          wdogCnt_d = '0;
          state_d   = WAIT_B;
        end
      end
      WAIT_B: begin
        // A B arriving on the last watchdog cycle still wins over the abort.
        if (m_axil_bvalid) begin
          respData_d  = '0;
          respError_d = 1'b0;
          state_d     = RESP;
        end else if (wdogExpired) begin
          respData_d  = '0;
          respError_d = 1'b1;
          state_d     = RESP;
        end else begin
          wdogCnt_d = wdogCnt_q + 1'b1;
        end
      end
      RD_ADDR: begin
        if (m_axil_arready) begin
          arValid_d = 1'b0;
          wdogCnt_d = '0;
          state_d   = WAIT_R;
        end
      end
      WAIT_R: begin
        if (m_axil_rvalid) begin
          respData_d  = m_axil_rdata;
          respError_d = (m_axil_rresp != 2'b00);
          state_d     = RESP;
        end else if (wdogExpired) begin
          respData_d  = '0;
          respError_d = 1'b1;
          state_d     = RESP;
        end else begin
          wdogCnt_d = wdogCnt_q + 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q     <= IDLE;
      reqAddr_q   <= '0;
      reqData_q   <= '0;
      reqStrb_q   <= '0;
      awValid_q   <= 1'b0;
      wValid_q    <= 1'b0;
      arValid_q   <= 1'b0;
      respData_q  <= '0;
      respError_q <= 1'b0;
      wdogCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      reqAddr_q   <= reqAddr_d;
      reqData_q   <= reqData_d;
      reqStrb_q   <= reqStrb_d;
      awValid_q   <= awValid_d;
      wValid_q    <= wValid_d;
      arValid_q   <= arValid_d;
      respData_q  <= respData_d;
      respError_q <= respError_d;
      wdogCnt_q   <= wdogCnt_d;
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = (state_q == RESP);
  assign resp_rdata     = respData_q;
  assign resp_error     = respError_q;
  assign m_axil_awaddr  = reqAddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awValid_q;
  assign m_axil_wdata   = reqData_q;
  assign m_axil_wstrb   = reqStrb_q;
  assign m_axil_wvalid  = wValid_q;
  assign m_axil_bready  = (state_q == WAIT_B);
  assign m_axil_araddr  = reqAddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arValid_q;
  assign m_axil_rready  = (state_q == WAIT_R);

endmodule
